// File: rtl/ram_dump_uart.sv
// ram_dump_uart
//   Streams a contiguous range of the scalar data RAM (port a) out as 8N1
//   UART frames once the CPU program has finished. While busy, this block
//   drives the RAM read address; a top-level mux hands port a back to the
//   CPU otherwise.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   start       one-cycle dump request, honoured only when idle
//   base_addr   first RAM address, captured when start is accepted
//   length      byte count, captured when start is accepted (0 = no dump)
//   mem_addr    registered RAM read address
//   mem_q       RAM read data, sampled in the last fetch cycle only
//   tx          UART serial output, idles high
//   busy        high from start acceptance until the done cycle
//   done        one-cycle completion pulse
//   bytes_sent  bytes fully transmitted in the current/last dump
module ram_dump_uart #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int RD_LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bytes_sent
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int LAT_W  = $clog2(RD_LATENCY + 1);
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LATENCY - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP,
        S_FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] shreg;
    logic [BAUD_W-1:0] baud_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [BIT_W-1:0]  bit_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            remaining  <= '0;
            shreg      <= '0;
            baud_cnt   <= '0;
            lat_cnt    <= '0;
            bit_idx    <= '0;
            mem_addr   <= '0;
            bytes_sent <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the branches below raise it
            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            remaining  <= length;
                            mem_addr   <= base_addr;
                            bytes_sent <= '0;
                            busy       <= 1'b1;
                            lat_cnt    <= '0;
                            state      <= S_FETCH;
                        end else begin
                            // empty request: acknowledge without touching the line
                            done <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    // tx stays high here, forming the inter-frame gap
                    if (lat_cnt == LAT_LAST) begin
                        shreg    <= mem_q;
                        tx       <= 1'b0;
                        baud_cnt <= BAUD_LAST;
                        state    <= S_START;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                S_START: begin
                    if (baud_cnt == '0) begin
                        // tx is registered, so the first data bit is put out
                        // on the edge that leaves the start bit
                        tx       <= shreg[0];
                        shreg    <= {1'b0, shreg[DATA_W-1:1]};
                        bit_idx  <= '0;
                        baud_cnt <= BAUD_LAST;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LAST;
                        if (bit_idx == BIT_LAST) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[DATA_W-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end

                S_STOP: begin
                    if (baud_cnt == '0) begin
                        bytes_sent <= bytes_sent + 1'b1;
                        remaining  <= remaining - 1'b1;
                        if (remaining == ADDR_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            // address wraps modulo 2^ADDR_W
                            mem_addr <= mem_addr + 1'b1;
                            lat_cnt  <= '0;
                            state    <= S_FETCH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dump_uart.sv
// tb_ram_dump_uart
//   Bench for ram_dump_uart with CLKS_PER_BIT=4 and RD_LATENCY=2. A frame
//   model turns each accepted request into the per-cycle outputs the block
//   must show; a serial decoder recovers bytes from tx independently.
module tb_ram_dump_uart;

    localparam int AW  = 16;
    localparam int CPB = 4;
    localparam int RDL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] length;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_q;
    logic          tx;
    logic          busy;
    logic          done;
    logic [AW-1:0] bytes_sent;

    always #5 clk = ~clk;

    ram_dump_uart #(
        .ADDR_W      (AW),
        .DATA_W      (8),
        .CLKS_PER_BIT(CPB),
        .RD_LATENCY  (RDL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .mem_addr  (mem_addr),
        .mem_q     (mem_q),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .bytes_sent(bytes_sent)
    );

    // RAM with two-cycle read latency: address registered once, then read,
    // so data for an address is valid in its second fetch cycle
    logic [7:0]    ram [0:65535];
    logic [AW-1:0] addr_q;
    always @(posedge clk) addr_q <= mem_addr;
    assign mem_q = ram[addr_q];

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- frame model ----------------
    typedef struct packed {
        logic          tx;
        logic          busy;
        logic          done;
        logic [AW-1:0] addr;
        logic [AW-1:0] bs;
    } exp_t;

    exp_t          expq [$];
    logic [AW-1:0] idle_addr = '0;
    logic [AW-1:0] idle_bs   = '0;

    // Queue expected outputs for every cycle after the accepting edge.
    task automatic push_model(input logic [AW-1:0] b, input logic [AW-1:0] n);
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [9:0]    frame;
        if (n == 0) begin
            expq.push_back('{1'b1, 1'b0, 1'b1, idle_addr, idle_bs});
        end else begin
            for (int k = 0; k < int'(n); k++) begin
                a     = b + AW'(k);
                d     = ram[a];
                frame = {1'b1, d, 1'b0};
                for (int c = 0; c < RDL; c++)
                    expq.push_back('{1'b1, 1'b1, 1'b0, a, AW'(k)});
                for (int bt = 0; bt < 10; bt++)
                    for (int c = 0; c < CPB; c++)
                        expq.push_back('{frame[bt], 1'b1, 1'b0, a, AW'(k)});
            end
            a = b + n - 1'b1;
            expq.push_back('{1'b1, 1'b0, 1'b1, a, n});
            idle_addr = a;
            idle_bs   = n;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("tx",         tx,         e.tx);
            chk("busy",       busy,       e.busy);
            chk("done",       done,       e.done);
            chk("mem_addr",   mem_addr,   e.addr);
            chk("bytes_sent", bytes_sent, e.bs);
        end else begin
            chk("idle_tx",         tx,         1);
            chk("idle_busy",       busy,       0);
            chk("idle_done",       done,       0);
            chk("idle_mem_addr",   mem_addr,   idle_addr);
            chk("idle_bytes_sent", bytes_sent, idle_bs);
        end
    end

    // ---------------- serial decoder ----------------
    logic [7:0] rxq [$];
    bit         rx_act = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            rx_act = 0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0)
                rx_sh[(rx_cnt - 6) / 4] = tx;
            if (rx_cnt == 38) begin
                chk("rx_stop_bit", tx, 1);
                rxq.push_back(rx_sh);
                rx_act = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        length    = n;
        @(posedge clk);
        push_model(b, n);
        #1;
        start     = 1'b0;
        base_addr = 16'hDEAD;
        length    = 16'h0BEE;
    endtask

    task automatic wait_model(input int budget);
        for (int i = 0; i < budget && expq.size() != 0; i++) @(posedge clk);
        chk("model_drain_timeout", expq.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_rx(input string nm, input logic [7:0] want [$]);
        chk({nm, "_count"}, rxq.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            if (i < rxq.size()) chk({nm, "_byte"}, rxq[i], want[i]);
        rxq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         a5_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic       trace [60];
        int         done_at;
        int         pulses;
        logic [7:0] want [$];

        for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 7 + 3);
        ram[16'h0010] = 8'hA5;
        ram[16'h0020] = 8'h01;
        ram[16'h0021] = 8'h80;
        ram[16'h0022] = 8'hFF;
        ram[16'hFFFF] = 8'h3C;
        ram[16'h0000] = 8'hC3;
        ram[16'h0040] = 8'h11;
        ram[16'h0041] = 8'h22;
        ram[16'h0042] = 8'h33;

        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        #12;
        chk("rst_tx",         tx,         1);
        chk("rst_busy",       busy,       0);
        chk("rst_done",       done,       0);
        chk("rst_mem_addr",   mem_addr,   0);
        chk("rst_bytes_sent", bytes_sent, 0);
        #10 reset = 1'b1;

        // single byte, exact bit timing and done latency
        launch(16'h0010, 16'd1);
        done_at = -1;
        pulses  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            trace[i] = tx;
            if (done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = i;
            end
        end
        chk("single_done_latency", done_at, 42);
        chk("single_done_pulses",  pulses,  1);
        chk("single_gap0", trace[0], 1);
        chk("single_gap1", trace[1], 1);
        for (int b = 0; b < 10; b++)
            for (int c = 0; c < CPB; c++)
                chk("single_a5_bit", trace[2 + 4 * b + c], a5_bits[b]);
        chk("single_bytes_sent", bytes_sent, 1);
        want = '{8'hA5};
        check_rx("single_rx", want);

        // multi byte
        launch(16'h0020, 16'd3);
        wait_model(400);
        chk("multi_bytes_sent", bytes_sent, 3);
        chk("multi_last_addr",  mem_addr,   16'h0022);
        want = '{8'h01, 8'h80, 8'hFF};
        check_rx("multi_rx", want);

        // address wrap
        launch(16'hFFFF, 16'd2);
        wait_model(300);
        chk("wrap_last_addr", mem_addr, 16'h0000);
        want = '{8'h3C, 8'hC3};
        check_rx("wrap_rx", want);

        // zero length
        launch(16'h0050, 16'd0);
        @(negedge clk);
        chk("len0_done", done, 1);
        wait_model(20);
        want = '{};
        check_rx("len0_rx", want);

        // start while busy is ignored
        launch(16'h0040, 16'd2);
        repeat (20) @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 16'h0041;
        length    = 16'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_model(300);
        chk("busy_start_bytes_sent", bytes_sent, 2);
        want = '{8'h11, 8'h22};
        check_rx("busy_start_rx", want);

        // reset mid-dump, then a clean single-byte dump
        launch(16'h0020, 16'd3);
        repeat (50) @(posedge clk);
        #2;
        reset = 1'b0;
        expq.delete();
        rxq.delete();
        idle_addr = '0;
        idle_bs   = '0;
        #1;
        chk("midrst_tx",         tx,         1);
        chk("midrst_busy",       busy,       0);
        chk("midrst_done",       done,       0);
        chk("midrst_mem_addr",   mem_addr,   0);
        chk("midrst_bytes_sent", bytes_sent, 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        launch(16'h0010, 16'd1);
        wait_model(200);
        chk("after_rst_bytes_sent", bytes_sent, 1);
        want = '{8'hA5};
        check_rx("after_rst_rx", want);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
